// File: rtl/expr_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : expr_result_checker
//  Description : Consumes the flattened result bus of an expression block
//                alongside the golden-model result for the same stimulus.
//                Counts vectors and mismatches, records the index of the
//                first failing vector and compacts every DUT result into a
//                MISR signature.
//                Optional feature macro: EXPR_CHECKER_DIFF_CAPTURE_EN
//                (adds first_diff = dut_y ^ ref_y of the first mismatch).
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_result_checker #(
    parameter int unsigned       WIDTH = 90,
    parameter int unsigned       CNT_W = 16,
    parameter int unsigned       SIG_W = 32,
    parameter logic [SIG_W-1:0]  POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]  SEED  = 32'hFFFFFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vectors,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   dut_y,
    input  logic [WIDTH-1:0]   ref_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   vec_cnt,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic [CNT_W-1:0]   first_fail_idx,
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
    output logic [WIDTH-1:0]   first_diff,
`endif
    output logic [SIG_W-1:0]   signature
);

    // Number of SIG_W-wide chunks the result bus is folded from
    localparam int unsigned NCHUNK = (WIDTH + SIG_W - 1) / SIG_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   num_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [CNT_W-1:0]   vec_cnt_q;
    logic [CNT_W-1:0]   mismatch_cnt_q;
    logic [CNT_W-1:0]   first_fail_idx_q;
    logic [SIG_W-1:0]   signature_q;
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
    logic [WIDTH-1:0]   first_diff_q;
`endif

    logic [NCHUNK*SIG_W-1:0] pad_y;
    logic [SIG_W-1:0]        fold;
    logic [SIG_W-1:0]        signature_d;
    logic                    accept;
    logic                    is_mismatch;
    logic [CNT_W-1:0]        vec_cnt_d;
    logic [CNT_W-1:0]        mismatch_cnt_d;
    logic                    last_vec;

    // Ready depends on state only so upstream never sees a valid->ready path
    assign in_ready = (state_q == ST_RUN);
    assign accept   = in_valid && in_ready;

    assign is_mismatch    = (dut_y != ref_y);
    assign vec_cnt_d      = vec_cnt_q + 1'b1;
    assign last_vec       = (vec_cnt_d == num_q);
    // Saturating mismatch count: stays at all-ones once reached
    assign mismatch_cnt_d = !is_mismatch            ? mismatch_cnt_q :
                            (mismatch_cnt_q == '1)  ? mismatch_cnt_q :
                                                      mismatch_cnt_q + 1'b1;

    // Fold the zero-padded result into one word, then advance the MISR
    always_comb begin
        pad_y            = '0;
        pad_y[WIDTH-1:0] = dut_y;
        fold             = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            fold = fold ^ pad_y[i*SIG_W +: SIG_W];
        end
        signature_d = {signature_q[SIG_W-2:0], 1'b0}
                    ^ (signature_q[SIG_W-1] ? POLY : '0)
                    ^ fold;
    end

    // Run-control FSM with all status outputs registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            num_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            vec_cnt_q        <= '0;
            mismatch_cnt_q   <= '0;
            first_fail_idx_q <= '1;
            signature_q      <= SEED;
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
            first_diff_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        num_q            <= num_vectors;
                        vec_cnt_q        <= '0;
                        mismatch_cnt_q   <= '0;
                        first_fail_idx_q <= '1;
                        signature_q      <= SEED;
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
                        first_diff_q     <= '0;
`endif
                        if (num_vectors == '0) begin
                            // Empty run completes immediately and passes
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored while a run is active
                    if (accept) begin
                        vec_cnt_q      <= vec_cnt_d;
                        mismatch_cnt_q <= mismatch_cnt_d;
                        signature_q    <= signature_d;
                        // A zero count means no earlier mismatch in this run
                        if (is_mismatch && (mismatch_cnt_q == '0)) begin
                            first_fail_idx_q <= vec_cnt_q;
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
                            first_diff_q     <= dut_y ^ ref_y;
`endif
                        end
                        if (last_vec) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mismatch_cnt_d == '0);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign vec_cnt        = vec_cnt_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign first_fail_idx = first_fail_idx_q;
    assign signature      = signature_q;
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
    assign first_diff     = first_diff_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_expr_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_expr_result_checker
//  Description : Self-checking bench for expr_result_checker. A transaction
//                level model tracks the run and is compared with the DUT
//                after every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_expr_result_checker;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_vectors;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] dut_y;
    logic [89:0] ref_y;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] vec_cnt;
    logic [15:0] mismatch_cnt;
    logic [15:0] first_fail_idx;
    logic [31:0] signature;
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
    logic [89:0] first_diff;
`endif

    expr_result_checker dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_vectors    (num_vectors),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .dut_y          (dut_y),
        .ref_y          (ref_y),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .vec_cnt        (vec_cnt),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx),
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
        .first_diff     (first_diff),
`endif
        .signature      (signature)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of one run
    bit          m_busy;
    bit          m_done;
    bit          m_pass;
    int          m_vec;
    int          m_mm;
    logic [15:0] m_ffi;
    logic [31:0] m_sig;
    logic [89:0] m_diff;
    int          m_target;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // MISR step: shift, polynomial feedback, XOR in the 32-bit fold of d
    function automatic logic [31:0] ref_sig(input logic [31:0] s, input logic [89:0] d);
        logic [31:0] f;
        f = 32'h0;
        for (int i = 0; i < 90; i += 32) f = f ^ 32'(d >> i);
        return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic logic [89:0] rand90();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[89:0];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_pass = 0;
        m_vec = 0; m_mm = 0; m_ffi = 16'hFFFF;
        m_sig = SEED; m_diff = '0; m_target = 0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".in_ready"},  in_ready,       m_busy);
        chk({ph, ".busy"},      busy,           m_busy);
        chk({ph, ".done"},      done,           m_done);
        chk({ph, ".pass"},      pass,           m_pass);
        chk({ph, ".vec_cnt"},   vec_cnt,        16'(m_vec));
        chk({ph, ".mm_cnt"},    mismatch_cnt,   16'(m_mm));
        chk({ph, ".ffi"},       first_fail_idx, m_ffi);
        chk({ph, ".signature"}, signature,      m_sig);
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
        chk({ph, ".first_diff"}, first_diff,    m_diff);
`endif
    endtask

    // One clock: drive at negedge, update model at posedge, compare at negedge
    task automatic cycle(input string ph, input bit rs, input bit st, input int nv,
                         input bit v, input logic [89:0] d, input logic [89:0] r);
        reset = rs; start = st; num_vectors = 16'(nv);
        in_valid = v; dut_y = d; ref_y = r;
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else if (!m_busy && st) begin
            m_vec = 0; m_mm = 0; m_ffi = 16'hFFFF; m_sig = SEED; m_diff = '0;
            m_target = nv;
            if (nv == 0) begin m_busy = 0; m_done = 1; m_pass = 1; end
            else         begin m_busy = 1; m_done = 0; m_pass = 0; end
        end else if (m_busy && v) begin
            if (d !== r) begin
                if (m_mm == 0) begin
                    m_ffi  = 16'(m_vec);
                    m_diff = d ^ r;
                end
                if (m_mm < 65535) m_mm++;
            end
            m_sig = ref_sig(m_sig, d);
            m_vec++;
            if (m_vec == m_target) begin
                m_busy = 0; m_done = 1; m_pass = (m_mm == 0);
            end
        end
        @(negedge clk);
        check_all(ph);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [89:0] d;
        logic [89:0] r;
        logic [89:0] b89;
        bit          pat [5];
        int          n;
        int          guard;

        b89 = 90'd1 << 89;
        reset = 1; start = 0; num_vectors = '0; in_valid = 0; dut_y = '0; ref_y = '0;
        model_reset();
        @(negedge clk);

        // Reset state
        cycle("rst", 1, 0, 0, 0, '0, '0);
        cycle("rst", 1, 0, 0, 0, '0, '0);
        chk("rst_ffi_const", first_fail_idx, 16'hFFFF);
        chk("rst_sig_const", signature, 32'hFFFFFFFF);
        cycle("idle", 0, 0, 0, 0, '0, '0);

        // Single all-zero vector
        cycle("t1", 0, 1, 1, 0, '0, '0);
        cycle("t1", 0, 0, 0, 1, '0, '0);
        chk("t1_sig_const", signature, 32'hFB3EE249);
        chk("t1_pass_const", pass, 1'b1);

        // Empty run: done next cycle, never ready
        cycle("t2", 0, 1, 0, 0, '0, '0);
        chk("t2_done_const", done, 1'b1);
        for (int i = 0; i < 3; i++) begin
            d = rand90();
            cycle("t2h", 0, 0, 0, 1, d, d);
        end
        chk("t2_sig_const", signature, 32'hFFFFFFFF);

        // Vectors 2 and 3 differ in bit 89
        cycle("t3", 0, 1, 4, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            d = rand90();
            r = (i >= 2) ? (d ^ b89) : d;
            cycle("t3", 0, 0, 0, 1, d, r);
        end
        chk("t3_mm_const", mismatch_cnt, 16'd2);
        chk("t3_ffi_const", first_fail_idx, 16'd2);
        chk("t3_pass_const", pass, 1'b0);
`ifdef EXPR_CHECKER_DIFF_CAPTURE_EN
        chk("t3_diff_const", first_diff, b89);
`endif

        // Bursty valid with data held by upstream
        pat = '{1, 0, 0, 1, 1};
        cycle("t4", 0, 1, 3, 0, '0, '0);
        d = rand90();
        for (int i = 0; i < 5; i++) cycle("t4", 0, 0, 0, pat[i], d, d);
        for (int i = 0; i < 2; i++) cycle("t4x", 0, 0, 0, 1, d, d);
        chk("t4_vec_const", vec_cnt, 16'd3);
        chk("t4_ready_const", in_ready, 1'b0);

        // Reset in the middle of a run, then a clean short run
        cycle("t5", 0, 1, 5, 0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            d = rand90();
            cycle("t5", 0, 0, 0, 1, d, d ^ b89);
        end
        cycle("t5r", 1, 0, 0, 0, '0, '0);
        chk("t5_busy_const", busy, 1'b0);
        cycle("t5b", 0, 1, 1, 0, '0, '0);
        d = rand90();
        cycle("t5b", 0, 0, 0, 1, d, d);
        chk("t5_vec_const", vec_cnt, 16'd1);
        chk("t5_done_const", done, 1'b1);

        // start re-pulsed during a run is ignored
        cycle("t6", 0, 1, 4, 0, '0, '0);
        d = rand90();
        cycle("t6", 0, 0, 0, 1, d, d);
        d = rand90();
        cycle("t6s", 0, 1, 9, 1, d, d);
        for (int i = 0; i < 5; i++) begin
            d = rand90();
            cycle("t6", 0, 0, 0, 1, d, d);
        end
        chk("t6_vec_const", vec_cnt, 16'd4);

        // Randomized runs
        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(1, 10);
            cycle("rnd", 0, 1, n, 0, '0, '0);
            guard = 0;
            while (m_busy && guard < 200) begin
                d = rand90();
                r = ($urandom_range(0, 2) == 0) ? (d ^ (90'd1 << $urandom_range(0, 89))) : d;
                cycle("rnd", 0, ($urandom_range(0, 9) == 0), $urandom_range(0, 20),
                      ($urandom_range(0, 3) != 0), d, r);
                guard++;
            end
            chk("rnd_end_done", done, 1'b1);
            if ($urandom_range(0, 1) == 1) cycle("rndi", 0, 0, 0, 1, rand90(), rand90());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/expr_result_checker.md
Name: expr_result_checker

Overview:
- Downstream consumer of the 90-bit flattened result bus of a vloghammer expression block.
- Accepts one result vector per handshake, together with the golden-model vector for the same stimulus.
- Compares the two vectors, counts mismatches and records the first failing index.
- Compacts the DUT results into a 32-bit MISR signature so regression runs can compare one word per test.

Parameters:
- WIDTH, 90, result bus width; must match the expression block's y.
- CNT_W, 16, width of the vector and mismatch counters.
- SIG_W, 32, MISR width.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, MISR value loaded at start.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run
- num_vectors  in  CNT_W  vectors in the run; sampled on start
- in_valid  in  1  dut_y/ref_y valid
- in_ready  out  1  checker accepts a vector this cycle
- dut_y  in  WIDTH  expression block output
- ref_y  in  WIDTH  golden-model output
- busy  out  1  run in progress
- done  out  1  run complete; held until next start or reset
- pass  out  1  done and mismatch_cnt==0
- vec_cnt  out  CNT_W  vectors accepted this run
- mismatch_cnt  out  CNT_W  mismatching vectors; saturates at all-ones
- first_fail_idx  out  CNT_W  index (0-based) of first mismatch; all-ones if none
- signature  out  SIG_W  MISR state

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high. All outputs are registered except in_ready.
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE; busy=0; done=0; pass=0; vec_cnt=0; mismatch_cnt=0; first_fail_idx=all-ones; signature=SEED.
- in_ready = (state==RUN). Combinational from state only; never depends on in_valid.
- A vector is accepted on a clk edge where in_valid && in_ready.
- IDLE or DONE, on start:
  - Clear counters, set first_fail_idx=all-ones, signature=SEED, latch num_vectors.
  - If latched value ==0: go to DONE (done=1, pass=1) next cycle.
  - Otherwise go to RUN (busy=1, done=0).
- RUN, on acceptance (all updates visible the next cycle):
  - vec_cnt increments.
  - If dut_y!=ref_y: mismatch_cnt increments (saturating); if this is the first mismatch, first_fail_idx=vec_cnt before increment.
  - signature = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(dut_y).
  - fold = dut_y[31:0] ^ dut_y[63:32] ^ {6'b0, dut_y[89:64]}.
- RUN to DONE: on the acceptance that makes vec_cnt==latched num_vectors. In that same edge: busy=0, done=1, pass=(final mismatch_cnt==0). in_ready drops the cycle after the final acceptance, so no extra vector is accepted.
- start during RUN: ignored.
- num_vectors changes while not sampling: ignored.
- in_valid with in_ready=0: no effect; upstream must hold data until accepted.
- Reset mid-run: returns to IDLE with reset values; the partial run is discarded.
- Counter saturation: mismatch_cnt stays at all-ones.
- vec_cnt never wraps, because the run ends at num_vectors ≤ 2^CNT_W-1.

Optional Feature:
- Macro: EXPR_CHECKER_DIFF_CAPTURE_EN.
- When defined:
  - Adds output first_diff [WIDTH-1:0] = dut_y ^ ref_y captured at the first mismatch.
  - first_diff is 0 at reset and at start; it is written once per run.
- When undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- Reset, start with num_vectors=1, one vector dut_y=ref_y=0 -> done=1, pass=1, vec_cnt=1, mismatch_cnt=0, first_fail_idx=16'hFFFF, signature=32'hFB3EE249.
- start with num_vectors=0 -> done=1, pass=1 one cycle later; in_ready never asserted; signature=32'hFFFFFFFF.
- num_vectors=4; vectors 2 and 3 differ in bit 89 -> mismatch_cnt=2, first_fail_idx=2, pass=0. With the macro: first_diff=1<<89.
- num_vectors=3, in_valid toggled 1,0,0,1,1 with upstream holding data -> exactly 3 acceptances; in_ready=0 the cycle after the third; vec_cnt=3.
- Reset asserted after 2 of 5 vectors -> all outputs at reset values. A new start with num_vectors=1 completes normally with vec_cnt=1.
- start pulsed during RUN (num_vectors=4, start re-pulsed with num_vectors=9 after vector 1) -> run still ends after 4 vectors; vec_cnt=4.
